// File: rtl/itcm_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// itcm_port_arbiter_pkg
//   Shared types and sizes for the ITCM port arbiter slice.
//   - ZCRV_ADDR_SIZE / ZCRV_INSTR_SIZE : core-wide address and instruction widths
//   - owner_e     : identifies which requester owns a RAM access / read response
//   - arb_state_e : arbitration FSM state encoding
// -----------------------------------------------------------------------------
package itcm_port_arbiter_pkg;

   localparam int ZCRV_ADDR_SIZE  = 32;
   localparam int ZCRV_INSTR_SIZE = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IFU  = 2'd1,
      OWN_LSU  = 2'd2,
      OWN_DBG  = 2'd3
   } owner_e;

   typedef enum logic [1:0] {
      ARB_NORM  = 2'd0,
      ARB_BOOST = 2'd1,
      ARB_LOCK  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/itcm_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// itcm_port_arbiter_if
//   Bundles the three requester ports (IFU, LSU, debug) and the ITCM macro
//   port seen by the arbiter.
//   Modports:
//     slave  : the arbiter (takes requests, drives grants/responses and ram_*)
//     master : the environment (requesters plus the ITCM macro)
//
//   Handshake: <x>_req is a per-cycle request with no holding obligation.
//   <x>_gnt high in the same cycle means the access was issued to the RAM in
//   that cycle; a write is complete at that point. For a granted read,
//   <x>_rvalid is high exactly one cycle later with <x>_rdata valid; rdata is
//   zero whenever rvalid is low. The IFU response is killed by ifu_flush in
//   its delivery cycle and is never replayed.
// -----------------------------------------------------------------------------
interface itcm_port_arbiter_if #(
   parameter int ADDR_W = itcm_port_arbiter_pkg::ZCRV_ADDR_SIZE,
   parameter int DATA_W = itcm_port_arbiter_pkg::ZCRV_INSTR_SIZE,
   parameter int RAM_AW = 14
);
   // IFU
   logic              ifu_req;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_flush;
   logic              ifu_gnt;
   logic              ifu_rvalid;
   logic [DATA_W-1:0] ifu_rdata;
   logic              ifu_stall;
   // LSU
   logic              lsu_req;
   logic              lsu_we;
   logic [3:0]        lsu_wmask;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic              lsu_gnt;
   logic              lsu_rvalid;
   logic [DATA_W-1:0] lsu_rdata;
   // Debug / boot loader
   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_lock;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic [DATA_W-1:0] dbg_rdata;
   // ITCM macro
   logic              ram_cs;
   logic              ram_we;
   logic [3:0]        ram_wmask;
   logic [RAM_AW-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  ifu_req, ifu_addr, ifu_flush,
      output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_stall,
      input  lsu_req, lsu_we, lsu_wmask, lsu_addr, lsu_wdata,
      output lsu_gnt, lsu_rvalid, lsu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
      output dbg_gnt, dbg_rvalid, dbg_rdata,
      output ram_cs, ram_we, ram_wmask, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output ifu_req, ifu_addr, ifu_flush,
      input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_stall,
      output lsu_req, lsu_we, lsu_wmask, lsu_addr, lsu_wdata,
      input  lsu_gnt, lsu_rvalid, lsu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
      input  dbg_gnt, dbg_rvalid, dbg_rdata,
      input  ram_cs, ram_we, ram_wmask, ram_addr, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/itcm_port_arbiter_rsp_router.sv
// -----------------------------------------------------------------------------
// itcm_rsp_router
//   Remembers who owns the RAM read issued this cycle and steers the RAM read
//   data to that requester on the following cycle.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     rd_owner           : owner of the read issued this cycle (OWN_NONE if none)
//     ifu_flush          : kills an IFU response in its delivery cycle
//     ram_rdata          : ITCM read data (valid the cycle after a read)
//     <x>_rvalid/<x>_rdata : per-requester response, rdata zero when not valid
// -----------------------------------------------------------------------------
module itcm_rsp_router
   import itcm_port_arbiter_pkg::*;
#(
   parameter int DATA_W = ZCRV_INSTR_SIZE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  owner_e            rd_owner,
   input  logic              ifu_flush,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ifu_rvalid,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              lsu_rvalid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata
);

   owner_e rsp_owner;

   // Reset clears the pending owner, so a response in flight is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_owner <= OWN_NONE;
      end else begin
         rsp_owner <= rd_owner;
      end
   end

   always_comb begin
      ifu_rvalid = (rsp_owner == OWN_IFU) && !ifu_flush;
      lsu_rvalid = (rsp_owner == OWN_LSU);
      dbg_rvalid = (rsp_owner == OWN_DBG);
      ifu_rdata  = ifu_rvalid ? ram_rdata : '0;
      lsu_rdata  = lsu_rvalid ? ram_rdata : '0;
      dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
   end

endmodule

// File: rtl/itcm_port_arbiter.sv
// -----------------------------------------------------------------------------
// itcm_port_arbiter
//   Shares the single-port ITCM between IFU fetch, LSU and debug/boot loader.
//   One access per cycle; read responses return one cycle later to their owner.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     bus         : itcm_port_arbiter_if.slave (requesters + ITCM macro)
//     arb_state   : current arbitration state (observation)
//     starve_cnt  : consecutive denied IFU cycles (observation)
//   Priorities: NORM dbg>lsu>ifu, BOOST dbg>ifu>lsu, LOCK dbg only.
// -----------------------------------------------------------------------------
module itcm_port_arbiter
   import itcm_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ZCRV_ADDR_SIZE,
   parameter int DATA_W     = ZCRV_INSTR_SIZE,
   parameter int RAM_AW     = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   itcm_port_arbiter_if.slave  bus,
   output arb_state_e          arb_state,
   output logic [3:0]          starve_cnt
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   owner_e            win;
   owner_e            rd_owner;
   logic              ram_we_c;
   logic [3:0]        ram_wmask_c;
   logic [RAM_AW-1:0] ram_addr_c;
   logic [DATA_W-1:0] ram_wdata_c;
   logic [3:0]        starve_nxt;
   logic              ifu_gnt_c;
   logic              unused_addr_bits;

   // Only the word-address field of each requester address reaches the RAM.
   assign unused_addr_bits = ^{bus.ifu_addr[ADDR_W-1:RAM_AW+2], bus.ifu_addr[1:0],
                               bus.lsu_addr[ADDR_W-1:RAM_AW+2], bus.lsu_addr[1:0],
                               bus.dbg_addr[ADDR_W-1:RAM_AW+2], bus.dbg_addr[1:0]};

   // Winner selection. Grants are gated by rst_n so nothing is granted while
   // the block is held in reset.
   always_comb begin
      win = OWN_NONE;
      if (rst_n) begin
         unique case (arb_state)
            ARB_LOCK: begin
               if (bus.dbg_req) win = OWN_DBG;
            end
            ARB_BOOST: begin
               if      (bus.dbg_req) win = OWN_DBG;
               else if (bus.ifu_req) win = OWN_IFU;
               else if (bus.lsu_req) win = OWN_LSU;
            end
            default: begin
               if      (bus.dbg_req) win = OWN_DBG;
               else if (bus.lsu_req) win = OWN_LSU;
               else if (bus.ifu_req) win = OWN_IFU;
            end
         endcase
      end
   end

   // RAM command mux.
   always_comb begin
      ram_we_c    = 1'b0;
      ram_wmask_c = 4'b0000;
      ram_addr_c  = '0;
      ram_wdata_c = '0;
      unique case (win)
         OWN_IFU: begin
            ram_addr_c = bus.ifu_addr[RAM_AW+1:2];
         end
         OWN_LSU: begin
            ram_we_c    = bus.lsu_we;
            ram_wmask_c = bus.lsu_we ? bus.lsu_wmask : 4'b0000;
            ram_addr_c  = bus.lsu_addr[RAM_AW+1:2];
            ram_wdata_c = bus.lsu_wdata;
         end
         OWN_DBG: begin
            ram_we_c    = bus.dbg_we;
            ram_wmask_c = bus.dbg_we ? 4'b1111 : 4'b0000;
            ram_addr_c  = bus.dbg_addr[RAM_AW+1:2];
            ram_wdata_c = bus.dbg_wdata;
         end
         default: ;
      endcase
   end

   assign ifu_gnt_c     = (win == OWN_IFU);
   assign bus.ifu_gnt   = ifu_gnt_c;
   assign bus.lsu_gnt   = (win == OWN_LSU);
   assign bus.dbg_gnt   = (win == OWN_DBG);
   assign bus.ifu_stall = bus.ifu_req & ~ifu_gnt_c;
   assign bus.ram_cs    = (win != OWN_NONE);
   assign bus.ram_we    = ram_we_c;
   assign bus.ram_wmask = ram_wmask_c;
   assign bus.ram_addr  = ram_addr_c;
   assign bus.ram_wdata = ram_wdata_c;

   // Writes finish at grant, so only reads claim the response slot.
   assign rd_owner = ram_we_c ? OWN_NONE : win;

   // Starvation count for the next cycle. Leaving LOCK clears it so the IFU
   // does not inherit debt accumulated before the lock.
   always_comb begin
      starve_nxt = starve_cnt;
      if (ifu_gnt_c) begin
         starve_nxt = '0;
      end else if (arb_state == ARB_LOCK) begin
         if (!bus.dbg_lock) starve_nxt = '0;
      end else if (bus.ifu_req && starve_cnt < STARVE_LIM) begin
         starve_nxt = starve_cnt + 4'd1;
      end
   end

   // BOOST is entered on the edge where the count reaches the limit, so the
   // IFU wins the very next cycle after STARVE_MAX denials.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_state  <= ARB_NORM;
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         unique case (arb_state)
            ARB_NORM: begin
               if (bus.dbg_lock)                  arb_state <= ARB_LOCK;
               else if (starve_nxt == STARVE_LIM) arb_state <= ARB_BOOST;
            end
            ARB_BOOST: begin
               if (bus.dbg_lock)   arb_state <= ARB_LOCK;
               else if (ifu_gnt_c) arb_state <= ARB_NORM;
            end
            ARB_LOCK: begin
               if (!bus.dbg_lock) arb_state <= ARB_NORM;
            end
            default: arb_state <= ARB_NORM;
         endcase
      end
   end

   itcm_rsp_router #(.DATA_W(DATA_W)) u_rsp_router (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_owner   (rd_owner),
      .ifu_flush  (bus.ifu_flush),
      .ram_rdata  (bus.ram_rdata),
      .ifu_rvalid (bus.ifu_rvalid),
      .ifu_rdata  (bus.ifu_rdata),
      .lsu_rvalid (bus.lsu_rvalid),
      .lsu_rdata  (bus.lsu_rdata),
      .dbg_rvalid (bus.dbg_rvalid),
      .dbg_rdata  (bus.dbg_rdata)
   );

endmodule

// File: tb/tb_itcm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_itcm_port_arbiter
//   Table-driven single-access vectors plus hand sequences for starvation
//   boost, flush, debug lock and reset during a pending response. Read
//   responses are tracked through an expected queue filled at grant time.
// -----------------------------------------------------------------------------
module tb_itcm_port_arbiter;
   import itcm_port_arbiter_pkg::*;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int RAM_AW     = 14;
   localparam int STARVE_MAX = 4;
   localparam int EXP_W      = 2 + DATA_W;

   // ---------------- clock / reset ----------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   arb_state_e arb_state;
   logic [3:0] starve_cnt;

   always #5 clk = ~clk;

   itcm_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW)) bus ();

   itcm_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .arb_state  (arb_state),
      .starve_cnt (starve_cnt)
   );

   // ---------------- stimulus types ----------------
   typedef struct {
      logic              ifu_req;
      logic [ADDR_W-1:0] ifu_addr;
      logic              ifu_flush;
      logic              lsu_req;
      logic              lsu_we;
      logic [3:0]        lsu_wmask;
      logic [ADDR_W-1:0] lsu_addr;
      logic [DATA_W-1:0] lsu_wdata;
      logic              dbg_req;
      logic              dbg_we;
      logic [ADDR_W-1:0] dbg_addr;
      logic [DATA_W-1:0] dbg_wdata;
      logic              dbg_lock;
   } stim_t;

   typedef struct {
      stim_t             s;
      owner_e            win;
      logic              we;
      logic [3:0]        wmask;
      logic [RAM_AW-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [3:0]        cnt_after;
   } vec_t;

   // ---------------- scoreboard ----------------
   int                n_checks = 0;
   int                n_errors = 0;
   logic [EXP_W-1:0]  exp_q[$];
   logic [DATA_W-1:0] rdata_plan = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic stim_t mk(
      input logic ifu_req, input logic [ADDR_W-1:0] ifu_addr, input logic ifu_flush,
      input logic lsu_req, input logic lsu_we, input logic [3:0] lsu_wmask,
      input logic [ADDR_W-1:0] lsu_addr, input logic [DATA_W-1:0] lsu_wdata,
      input logic dbg_req, input logic dbg_we, input logic [ADDR_W-1:0] dbg_addr,
      input logic [DATA_W-1:0] dbg_wdata, input logic dbg_lock);
      stim_t s;
      s.ifu_req   = ifu_req;   s.ifu_addr  = ifu_addr;  s.ifu_flush = ifu_flush;
      s.lsu_req   = lsu_req;   s.lsu_we    = lsu_we;    s.lsu_wmask = lsu_wmask;
      s.lsu_addr  = lsu_addr;  s.lsu_wdata = lsu_wdata;
      s.dbg_req   = dbg_req;   s.dbg_we    = dbg_we;    s.dbg_addr  = dbg_addr;
      s.dbg_wdata = dbg_wdata; s.dbg_lock  = dbg_lock;
      return s;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply(input stim_t s);
      bus.ifu_req   = s.ifu_req;   bus.ifu_addr  = s.ifu_addr;  bus.ifu_flush = s.ifu_flush;
      bus.lsu_req   = s.lsu_req;   bus.lsu_we    = s.lsu_we;    bus.lsu_wmask = s.lsu_wmask;
      bus.lsu_addr  = s.lsu_addr;  bus.lsu_wdata = s.lsu_wdata;
      bus.dbg_req   = s.dbg_req;   bus.dbg_we    = s.dbg_we;    bus.dbg_addr  = s.dbg_addr;
      bus.dbg_wdata = s.dbg_wdata; bus.dbg_lock  = s.dbg_lock;
   endtask

   // Pops the response expected in this cycle; an empty queue means none.
   task automatic check_rsp(input logic flush);
      logic [EXP_W-1:0]  e;
      owner_e            o;
      logic [DATA_W-1:0] d;
      logic              iv, lv, dv;
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      o  = owner_e'(e[EXP_W-1 -: 2]);
      d  = e[DATA_W-1:0];
      iv = (o == OWN_IFU) && !flush;
      lv = (o == OWN_LSU);
      dv = (o == OWN_DBG);
      chk("ifu_rvalid", 64'(bus.ifu_rvalid), 64'(iv));
      chk("ifu_rdata",  64'(bus.ifu_rdata),  iv ? 64'(d) : 64'd0);
      chk("lsu_rvalid", 64'(bus.lsu_rvalid), 64'(lv));
      chk("lsu_rdata",  64'(bus.lsu_rdata),  lv ? 64'(d) : 64'd0);
      chk("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(dv));
      chk("dbg_rdata",  64'(bus.dbg_rdata),  dv ? 64'(d) : 64'd0);
   endtask

   // One clock cycle: drive, check this cycle's response and grant, then plan
   // the RAM data returned next cycle and record who should receive it.
   task automatic do_cycle(input stim_t s, input owner_e win, input logic we,
                           input logic [3:0] wmask, input logic [RAM_AW-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input arb_state_e st,
                           input logic [3:0] cnt);
      owner_e o;
      @(posedge clk);
      #1;
      apply(s);
      bus.ram_rdata = rdata_plan;
      #1;
      check_rsp(s.ifu_flush);
      chk("arb_state",  64'(arb_state),  64'(st));
      chk("starve_cnt", 64'(starve_cnt), 64'(cnt));
      chk("ifu_gnt",    64'(bus.ifu_gnt),   64'(win == OWN_IFU));
      chk("lsu_gnt",    64'(bus.lsu_gnt),   64'(win == OWN_LSU));
      chk("dbg_gnt",    64'(bus.dbg_gnt),   64'(win == OWN_DBG));
      chk("ifu_stall",  64'(bus.ifu_stall), 64'(s.ifu_req && win != OWN_IFU));
      chk("ram_cs",     64'(bus.ram_cs),    64'(win != OWN_NONE));
      chk("ram_we",     64'(bus.ram_we),    64'(win != OWN_NONE && we));
      if (win != OWN_NONE) chk("ram_addr", 64'(bus.ram_addr), 64'(addr));
      if (win == OWN_IFU || we) chk("ram_wmask", 64'(bus.ram_wmask), 64'(wmask));
      if (we) chk("ram_wdata", 64'(bus.ram_wdata), 64'(wdata));
      rdata_plan = $urandom;
      o = (win != OWN_NONE && !we) ? win : OWN_NONE;
      exp_q.push_back({o, rdata_plan});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      apply(mk(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0));
      bus.ram_rdata = 32'hA5A5_5A5A;
      #1;
      chk("rst ifu_rvalid", 64'(bus.ifu_rvalid), 64'd0);
      chk("rst lsu_rvalid", 64'(bus.lsu_rvalid), 64'd0);
      chk("rst dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
      chk("rst ifu_rdata",  64'(bus.ifu_rdata),  64'd0);
      chk("rst lsu_rdata",  64'(bus.lsu_rdata),  64'd0);
      chk("rst dbg_rdata",  64'(bus.dbg_rdata),  64'd0);
      chk("rst gnts",       64'({bus.ifu_gnt, bus.lsu_gnt, bus.dbg_gnt}), 64'd0);
      chk("rst ifu_stall",  64'(bus.ifu_stall),  64'd1);
      chk("rst ram_cs",     64'(bus.ram_cs),     64'd0);
      chk("rst ram_we",     64'(bus.ram_we),     64'd0);
      chk("rst arb_state",  64'(arb_state),      64'(ARB_NORM));
      chk("rst starve_cnt", 64'(starve_cnt),     64'd0);
      repeat (2) @(posedge clk);
      #1;
      apply(mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0));
      rst_n = 1'b1;
      exp_q.delete();
      rdata_plan = '0;
   endtask

   // ---------------- test ----------------
   vec_t  vecs[8];
   stim_t idle;
   stim_t sv;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      idle = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      apply(idle);
      bus.ram_rdata = '0;

      // stimulus, winner, we, wmask, ram_addr, wdata, starve_cnt after the cycle
      vecs[0] = '{mk(1, 32'h8000_0010, 0, 0, 0, 4'h0, '0, '0, 0, 0, '0, '0, 0),
                  OWN_IFU, 1'b0, 4'h0, 14'h0004, '0, 4'd0};
      vecs[1] = '{mk(1, 32'h8000_0010, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 0, 0, '0, '0, 0),
                  OWN_LSU, 1'b0, 4'h0, 14'h0040, '0, 4'd1};
      vecs[2] = '{mk(0, '0, 0, 1, 1, 4'b0110, 32'h8000_0204, 32'h1122_3344, 0, 0, '0, '0, 0),
                  OWN_LSU, 1'b1, 4'b0110, 14'h0081, 32'h1122_3344, 4'd0};
      vecs[3] = '{mk(1, 32'h8000_0020, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 1, 0, 32'h8000_0FFC, '0, 0),
                  OWN_DBG, 1'b0, 4'h0, 14'h03FF, '0, 4'd1};
      vecs[4] = '{mk(0, '0, 0, 1, 1, 4'b0001, 32'h8000_0300, 32'h5555_AAAA, 1, 1, 32'h8000_0008, 32'hCAFE_F00D, 0),
                  OWN_DBG, 1'b1, 4'hF, 14'h0002, 32'hCAFE_F00D, 4'd0};
      vecs[5] = '{mk(1, 32'h0001_FFFF, 0, 0, 0, 4'h0, '0, '0, 0, 0, '0, '0, 0),
                  OWN_IFU, 1'b0, 4'h0, 14'h3FFF, '0, 4'd0};
      vecs[6] = '{idle, OWN_NONE, 1'b0, 4'h0, '0, '0, 4'd0};
      vecs[7] = '{mk(0, '0, 0, 1, 0, 4'h0, 32'hFFFF_FFF0, '0, 0, 0, '0, '0, 0),
                  OWN_LSU, 1'b0, 4'h0, 14'h3FFC, '0, 4'd0};

      for (int i = 0; i < 8; i++) begin
         do_reset();
         do_cycle(vecs[i].s, vecs[i].win, vecs[i].we, vecs[i].wmask, vecs[i].addr,
                  vecs[i].wdata, ARB_NORM, 4'd0);
         do_cycle(idle, OWN_NONE, 1'b0, 4'h0, '0, '0, ARB_NORM, vecs[i].cnt_after);
      end

      // Starvation: four denials, boosted IFU wins, then back to normal.
      do_reset();
      sv = mk(1, 32'h8000_0040, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 0, 0, '0, '0, 0);
      for (int i = 0; i < STARVE_MAX; i++)
         do_cycle(sv, OWN_LSU, 1'b0, 4'h0, 14'h0040, '0, ARB_NORM, 4'(i));
      do_cycle(sv, OWN_IFU, 1'b0, 4'h0, 14'h0010, '0, ARB_BOOST, 4'd4);
      do_cycle(sv, OWN_LSU, 1'b0, 4'h0, 14'h0040, '0, ARB_NORM, 4'd0);
      do_cycle(idle, OWN_NONE, 1'b0, 4'h0, '0, '0, ARB_NORM, 4'd1);

      // Flush: IFU response dropped, same-cycle fetch served; LSU unaffected.
      do_reset();
      do_cycle(mk(1, 32'h8000_0100, 0, 0, 0, 4'h0, '0, '0, 0, 0, '0, '0, 0),
               OWN_IFU, 1'b0, 4'h0, 14'h0040, '0, ARB_NORM, 4'd0);
      do_cycle(mk(1, 32'h8000_0200, 1, 0, 0, 4'h0, '0, '0, 0, 0, '0, '0, 0),
               OWN_IFU, 1'b0, 4'h0, 14'h0080, '0, ARB_NORM, 4'd0);
      do_cycle(mk(1, 32'h8000_0204, 0, 1, 0, 4'h0, 32'h8000_0300, '0, 0, 0, '0, '0, 0),
               OWN_LSU, 1'b0, 4'h0, 14'h00C0, '0, ARB_NORM, 4'd0);
      do_cycle(mk(1, 32'h8000_0204, 1, 0, 0, 4'h0, '0, '0, 0, 0, '0, '0, 0),
               OWN_IFU, 1'b0, 4'h0, 14'h0081, '0, ARB_NORM, 4'd1);
      do_cycle(idle, OWN_NONE, 1'b0, 4'h0, '0, '0, ARB_NORM, 4'd0);

      // Debug lock: in-flight LSU read still returns, only debug granted,
      // count frozen in LOCK and cleared on exit.
      do_reset();
      do_cycle(mk(1, 32'h8000_0010, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 0, 0, '0, '0, 1),
               OWN_LSU, 1'b0, 4'h0, 14'h0040, '0, ARB_NORM, 4'd0);
      do_cycle(mk(1, 32'h8000_0010, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 1, 1, 32'h8000_0000, 32'hDEAD_BEEF, 1),
               OWN_DBG, 1'b1, 4'hF, 14'h0000, 32'hDEAD_BEEF, ARB_LOCK, 4'd1);
      do_cycle(mk(1, 32'h8000_0010, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 1, 0, 32'h8000_0004, '0, 1),
               OWN_DBG, 1'b0, 4'h0, 14'h0001, '0, ARB_LOCK, 4'd1);
      do_cycle(mk(1, 32'h8000_0010, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 0, 0, '0, '0, 1),
               OWN_NONE, 1'b0, 4'h0, '0, '0, ARB_LOCK, 4'd1);
      do_cycle(mk(1, 32'h8000_0010, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 0, 0, '0, '0, 0),
               OWN_NONE, 1'b0, 4'h0, '0, '0, ARB_LOCK, 4'd1);
      do_cycle(mk(1, 32'h8000_0010, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 0, 0, '0, '0, 0),
               OWN_LSU, 1'b0, 4'h0, 14'h0040, '0, ARB_NORM, 4'd0);
      do_cycle(idle, OWN_NONE, 1'b0, 4'h0, '0, '0, ARB_NORM, 4'd1);

      // Reset while an LSU response is pending: it must never appear.
      do_reset();
      do_cycle(mk(0, '0, 0, 1, 0, 4'h0, 32'h8000_0100, '0, 0, 0, '0, '0, 0),
               OWN_LSU, 1'b0, 4'h0, 14'h0040, '0, ARB_NORM, 4'd0);
      do_reset();
      do_cycle(idle, OWN_NONE, 1'b0, 4'h0, '0, '0, ARB_NORM, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
